// File: rtl/vx_tag_reorder.sv
// vx_tag_reorder: hands out tags in circular order and retires out-of-order responses in allocation order.
// Optional one-entry output register: define VX_TAG_REORDER_OUTREG_EN.
module vx_tag_reorder #(
  parameter int DATAW = 1,
  parameter int SIZE  = 4,
  parameter int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [ADDRW-1:0] alloc_tag,
  input  logic             resp_valid,
  input  logic [ADDRW-1:0] resp_tag,
  input  logic [DATAW-1:0] resp_data,
  output logic             out_valid,
  output logic [ADDRW-1:0] out_tag,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             empty,
  output logic             full
);
  localparam int CNTW = $clog2(SIZE + 1);

  logic [ADDRW-1:0] wr_ptr;
  logic [ADDRW-1:0] rd_ptr;
  logic [CNTW-1:0]  count;
  logic [SIZE-1:0]  done;
  logic [DATAW-1:0] ram [SIZE];

  logic head_valid;
  logic deq_ready;
  logic alloc_fire;
  logic pop;

  function automatic logic [ADDRW-1:0] ptr_inc(input logic [ADDRW-1:0] p);
    ptr_inc = (p == ADDRW'(SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == CNTW'(SIZE));
  assign empty       = (count == '0);
  assign alloc_ready = ~full;
  assign alloc_tag   = wr_ptr;
  assign head_valid  = done[rd_ptr];
  assign alloc_fire  = alloc_valid & ~full;
  assign pop         = head_valid & deq_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)        rd_ptr <= ptr_inc(rd_ptr);
      case ({alloc_fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A legal response never targets the head in the cycle it retires, so the order of these two is moot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= '0;
    end else begin
      if (pop)        done[rd_ptr]   <= 1'b0;
      if (resp_valid) done[resp_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_valid) ram[resp_tag] <= resp_data;
  end

`ifdef VX_TAG_REORDER_OUTREG_EN
  logic             oreg_valid;
  logic [ADDRW-1:0] oreg_tag;
  logic [DATAW-1:0] oreg_data;

  // The register refills whenever it is vacant or being drained, so throughput stays one per cycle.
  assign deq_ready = ~oreg_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreg_valid <= 1'b0;
      oreg_tag   <= '0;
      oreg_data  <= '0;
    end else if (deq_ready) begin
      oreg_valid <= head_valid;
      oreg_tag   <= rd_ptr;
      oreg_data  <= ram[rd_ptr];
    end
  end

  assign out_valid = oreg_valid;
  assign out_tag   = oreg_tag;
  assign out_data  = oreg_data;
`else
  assign deq_ready = out_ready;
  assign out_valid = head_valid;
  assign out_tag   = rd_ptr;
  assign out_data  = ram[rd_ptr];
`endif

`ifndef SYNTHESIS
  int resp_off;
  always_comb resp_off = (int'(resp_tag) + SIZE - int'(rd_ptr)) % SIZE;

  // A response must name a tag that is in flight and not yet completed.
  always @(posedge clk) begin
    if (!reset && resp_valid)
      assert (resp_off < int'(count) && !done[resp_tag]);
  end
`endif

endmodule

// File: tb/tb_vx_tag_reorder.sv
// Scoreboard bench for vx_tag_reorder: queue-based reference model, directed scenarios plus random traffic.
module tb_vx_tag_reorder;
  localparam int SIZE  = 4;
  localparam int DATAW = 8;
  localparam int ADDRW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             alloc_valid = 1'b0;
  logic             alloc_ready;
  logic [ADDRW-1:0] alloc_tag;
  logic             resp_valid = 1'b0;
  logic [ADDRW-1:0] resp_tag = '0;
  logic [DATAW-1:0] resp_data = '0;
  logic             out_valid;
  logic [ADDRW-1:0] out_tag;
  logic [DATAW-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             empty;
  logic             full;

  always #5 clk = ~clk;

  vx_tag_reorder #(.DATAW(DATAW), .SIZE(SIZE), .ADDRW(ADDRW)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_ready(out_ready),
    .empty(empty), .full(full)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: tags in allocation order plus per-tag completion state.
  int         q[$];
  bit         done_m [SIZE];
  logic [7:0] data_m [SIZE];
  int         wr_m = 0;

  typedef struct {
    int         tag;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  bit e_valid, e_ready, e_empty, e_full;
  int e_tag;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    e_valid = (q.size() > 0) && done_m[q[0]];
    e_ready = (q.size() < SIZE);
    e_empty = (q.size() == 0);
    e_full  = (q.size() == SIZE);
    e_tag   = wr_m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus, push the predicted retire, then advance the model past the edge.
  task automatic step(input bit av, input bit rv, input int rt, input logic [7:0] rd, input bit ordy);
    bit will_alloc, will_retire;
    refresh();
    alloc_valid = av;
    resp_valid  = rv;
    resp_tag    = ADDRW'(rt);
    resp_data   = rd;
    out_ready   = ordy;
    will_alloc  = av && e_ready;
    will_retire = ordy && e_valid;
    if (will_retire) exp_q.push_back('{q[0], data_m[q[0]]});
    tick();
    if (will_retire) begin
      done_m[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (will_alloc) begin
      q.push_back(wr_m);
      wr_m = (wr_m + 1) % SIZE;
    end
    if (rv) begin
      done_m[rt] = 1'b1;
      data_m[rt] = rd;
    end
    refresh();
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0;
    resp_valid  = 1'b0;
    out_ready   = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_alloc_ready", int'(alloc_ready), 1);
    q.delete();
    exp_q.delete();
    foreach (done_m[i]) done_m[i] = 1'b0;
    wr_m = 0;
    refresh();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: compares flags against the model and pops the scoreboard on every retire handshake.
  initial begin
    bit         prev_hold = 1'b0;
    int         prev_tag = 0;
    int         prev_data = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (prev_hold) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_tag", int'(out_tag), prev_tag);
          chk("hold_data", int'(out_data), prev_data);
        end
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("alloc_ready", int'(alloc_ready), int'(e_ready));
        chk("empty", int'(empty), int'(e_empty));
        chk("full", int'(full), int'(e_full));
        if (alloc_valid && alloc_ready) chk("alloc_tag", int'(alloc_tag), e_tag);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL retire: unexpected tag %0d data %02h, expected none", out_tag, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_tag", int'(out_tag), e.tag);
            chk("out_data", int'(out_data), int'(e.data));
            $display("retire tag=%0d data=%02h", out_tag, out_data);
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_tag  = int'(out_tag);
        prev_data = int'(out_data);
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    int cand[$];
    bit rv;
    int rt;
    #1 reset = 1'b1;
    #1;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_empty", int'(empty), 1);
    chk("init_alloc_ready", int'(alloc_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    refresh();

`ifdef VX_TAG_REORDER_OUTREG_EN
    alloc_valid = 1'b1;
    tick();
    tick();
    alloc_valid = 1'b0;
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = 8'h11;
    tick();
    chk("oreg_latency", int'(out_valid), 0);
    resp_tag = 2'd1; resp_data = 8'h22;
    tick();
    resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("oreg_hold_valid", int'(out_valid), 1);
      chk("oreg_hold_tag", int'(out_tag), 0);
      chk("oreg_hold_data", int'(out_data), 'h11);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("oreg_second_valid", int'(out_valid), 1);
    chk("oreg_second_tag", int'(out_tag), 1);
    chk("oreg_second_data", int'(out_data), 'h22);
    tick();
    chk("oreg_drained", int'(out_valid), 0);
    chk("oreg_empty", int'(empty), 1);
`else
    mon_en = 1'b1;

    // In order
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 1);
    step(0, 1, 0, 8'h11, 1);
    step(0, 1, 1, 8'h22, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);

    // Reorder
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 1);
    step(0, 1, 2, 8'hC2, 1);
    step(0, 1, 1, 8'hB1, 1);
    step(0, 1, 0, 8'hA0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);

    // Full, ignored fifth allocate, wrap back to tag 0
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h50, 0);
    step(0, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    // Simultaneous allocate, response and retire at count 2
    do_reset();
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h34, 0);
    step(1, 1, 1, 8'h35, 1);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    // Reset with three tags in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
    do_reset();
    step(1, 0, 0, 8'h00, 0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cand.delete();
      foreach (q[i]) if (!done_m[q[i]]) cand.push_back(q[i]);
      rv = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
      rt = rv ? cand[$urandom_range(0, cand.size() - 1)] : 0;
      step($urandom_range(0, 2) != 0, rv, rt, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 20; n++) begin
      cand.delete();
      foreach (q[i]) if (!done_m[q[i]]) cand.push_back(q[i]);
      rv = (cand.size() > 0);
      rt = rv ? cand[0] : 0;
      step(0, rv, rt, 8'($urandom), 1);
    end
    step(0, 0, 0, 8'h00, 1);
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_empty", int'(empty), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
